// File: rtl/n64_joybus_host.sv
// Joybus (N64 SI) host: sends a 1-8 byte command on an open-drain line and decodes a 0-8 byte reply.
// Optional RX timeouts are enabled by defining JOYBUS_HOST_TIMEOUT_EN.
module n64_joybus_host #(
  parameter int unsigned QUARTER_CYCLES      = 100,
  parameter int unsigned RX_TIMEOUT_QUARTERS = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  inout  wire         io_joybus_dq,
  input  logic        i_start,
  input  logic [3:0]  i_tx_length,
  input  logic [3:0]  i_rx_length,
  input  logic [63:0] i_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [63:0] o_rx_data,
  output logic [3:0]  o_rx_count
);

  localparam int unsigned QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QW-1:0] QLast = QW'(QUARTER_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StCheck  = 3'd1;
  localparam logic [2:0] StTxBit  = 3'd2;
  localparam logic [2:0] StTxStop = 3'd3;
  localparam logic [2:0] StRxWait = 3'd4;
  localparam logic [2:0] StRxBit  = 3'd5;
  localparam logic [2:0] StRxStop = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          dq_q, dq_d;
  logic [2:0]    sync_q;
  logic          line, fall;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qidx_q, qidx_d;
  logic          quarter_end, restart, timeout;
  logic [6:0]    bit_cnt_q, bit_cnt_d;
  logic [63:0]   tx_sr_q, tx_sr_d;
  logic [3:0]    tx_len_q, tx_len_d;
  logic [3:0]    rx_len_q, rx_len_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [63:0]   rx_data_q, rx_data_d;
  logic [3:0]    rx_count_q, rx_count_d;
  logic          error_q, error_d;
  logic          stop_seen_q, stop_seen_d;
  logic [6:0]    tx_last;
  logic [7:0]    rx_next_byte;

  assign io_joybus_dq = dq_q ? 1'bz : 1'b0;

  // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
  assign line         = sync_q[1];
  assign fall         = sync_q[2] & ~sync_q[1];
  assign quarter_end  = (qcnt_q == QLast);
  assign tx_last      = {tx_len_q, 3'b000} - 7'd1;
  assign rx_next_byte = {rx_byte_q[6:0], line};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], io_joybus_dq};
    end
  end

  always_comb begin
    qcnt_d = quarter_end ? '0 : qcnt_q + QW'(1);
    qidx_d = quarter_end ? qidx_q + 2'd1 : qidx_q;
    if (restart) begin
      qcnt_d = '0;
      qidx_d = '0;
    end
  end

`ifdef JOYBUS_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RX_TIMEOUT_QUARTERS + 1);
  logic [TW-1:0] tq_q, tq_d;

  always_comb begin
    tq_d = tq_q;
    if (restart) begin
      tq_d = '0;
    end else if (quarter_end) begin
      tq_d = tq_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tq_q <= '0;
    end else begin
      tq_q <= tq_d;
    end
  end

  assign timeout = quarter_end && (tq_q == TW'(RX_TIMEOUT_QUARTERS - 1));
`else
  // Without the timeout counter the parameter has no effect
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^RX_TIMEOUT_QUARTERS;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dq_d        = dq_q;
    restart     = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    tx_len_d    = tx_len_q;
    rx_len_d    = rx_len_q;
    rx_byte_d   = rx_byte_q;
    rx_data_d   = rx_data_q;
    rx_count_d  = rx_count_q;
    error_d     = error_q;
    stop_seen_d = stop_seen_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d    = StCheck;
          tx_sr_d    = i_tx_data;
          tx_len_d   = i_tx_length;
          rx_len_d   = i_rx_length;
          rx_data_d  = '0;
          rx_count_d = '0;
          error_d    = 1'b0;
        end
      end
      StCheck: begin
        if (tx_len_q == 4'd0 || tx_len_q > 4'd8 || rx_len_q > 4'd8 || !line) begin
          state_d = StDone;
          error_d = 1'b1;
        end else begin
          state_d   = StTxBit;
          dq_d      = 1'b0;
          restart   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StTxBit: begin
        if (quarter_end) begin
          // '1' releases after quarter 0, '0' after quarter 2
          if ((qidx_q == 2'd0 && tx_sr_q[63]) || qidx_q == 2'd2) begin
            dq_d = 1'b1;
          end
          if (qidx_q == 2'd3) begin
            dq_d = 1'b0;
            if (bit_cnt_q == tx_last) begin
              state_d = StTxStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
              tx_sr_d   = {tx_sr_q[62:0], 1'b0};
            end
          end
        end
      end
      StTxStop: begin
        if (quarter_end) begin
          dq_d      = 1'b1;
          restart   = 1'b1;
          bit_cnt_d = '0;
          state_d   = (rx_len_q == 4'd0) ? StDone : StRxWait;
        end
      end
      StRxWait: begin
        if (fall) begin
          state_d = StRxBit;
          restart = 1'b1;
        end else if (timeout) begin
          state_d = StDone;
          error_d = 1'b1;
        end
      end
      StRxBit: begin
        if (quarter_end && qidx_q == 2'd1) begin
          restart   = 1'b1;
          rx_byte_d = rx_next_byte;
          bit_cnt_d = bit_cnt_q + 7'd1;
          state_d   = StRxWait;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_data_q | ({rx_next_byte, 56'd0} >> {rx_count_q[2:0], 3'b000});
            rx_count_d = rx_count_q + 4'd1;
            if (rx_count_q + 4'd1 == rx_len_q) begin
              state_d     = StRxStop;
              stop_seen_d = 1'b0;
            end
          end
        end
      end
      StRxStop: begin
        if (!stop_seen_q) begin
          if (fall) begin
            stop_seen_d = 1'b1;
            restart     = 1'b1;
          end else if (timeout) begin
            state_d = StDone;
            error_d = 1'b1;
          end
        end else if (line) begin
          state_d = StDone;
        end else if (timeout) begin
          state_d = StDone;
          error_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      dq_q        <= 1'b1;
      qcnt_q      <= '0;
      qidx_q      <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      tx_len_q    <= '0;
      rx_len_q    <= '0;
      rx_byte_q   <= '0;
      rx_data_q   <= '0;
      rx_count_q  <= '0;
      error_q     <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dq_q        <= dq_d;
      qcnt_q      <= qcnt_d;
      qidx_q      <= qidx_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      tx_len_q    <= tx_len_d;
      rx_len_q    <= rx_len_d;
      rx_byte_q   <= rx_byte_d;
      rx_data_q   <= rx_data_d;
      rx_count_q  <= rx_count_d;
      error_q     <= error_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign o_busy     = (state_q != StIdle) && (state_q != StDone);
  assign o_done     = (state_q == StDone);
  assign o_error    = error_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_count = rx_count_q;

endmodule

// File: tb/tb_n64_joybus_host.sv
// Directed bench for n64_joybus_host: bit timing, replies, length/stuck-bus errors, reset.
// The silent-device step adapts to whether JOYBUS_HOST_TIMEOUT_EN is defined.
module tb_n64_joybus_host;
  localparam int unsigned Q = 100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  tx_len, rx_len;
  logic [63:0] tx_data;
  logic        busy, done, error;
  logic [63:0] rx_data;
  logic [3:0]  rx_count;
  logic        dev_low;
  wire         dq;
  int          passed = 0;
  int          total  = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  pullup (dq);
  assign dq = dev_low ? 1'b0 : 1'bz;

  n64_joybus_host #(
    .QUARTER_CYCLES(Q),
    .RX_TIMEOUT_QUARTERS(64)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .io_joybus_dq(dq),
    .i_start(start),
    .i_tx_length(tx_len),
    .i_rx_length(rx_len),
    .i_tx_data(tx_data),
    .o_busy(busy),
    .o_done(done),
    .o_error(error),
    .o_rx_data(rx_data),
    .o_rx_count(rx_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h (failure #%0d)", tag, obs, exp, fails);
    end
  endtask

  // Steps negedges until dq reaches lvl; n is the number of cycles waited.
  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    while (dq !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns at the negedge after the accepting posedge (DUT in its first busy cycle).
  task automatic do_start(input logic [3:0] tl, input logic [3:0] rl, input logic [63:0] td);
    @(negedge clk);
    tx_len  = tl;
    rx_len  = rl;
    tx_data = td;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Skips over the host's command bits and stop bit; returns once the line is released.
  task automatic skip_host_tx(input int nbytes);
    int n;
    for (int i = 0; i < nbytes * 8 + 1; i++) begin
      wait_level(1'b0, 1000, n);
      wait_level(1'b1, 1000, n);
    end
  endtask

  task automatic dev_send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      dev_low = 1'b1;
      repeat (b[i] ? Q : 3 * Q) @(negedge clk);
      dev_low = 1'b0;
      repeat (b[i] ? 3 * Q : Q) @(negedge clk);
    end
  endtask

  task automatic dev_stop();
    dev_low = 1'b1;
    repeat (2 * Q) @(negedge clk);
    dev_low = 1'b0;
  endtask

  initial begin
    int lo, hi, n;
    logic drove;
    reset_n = 1'b0;
    start   = 1'b0;
    tx_len  = '0;
    rx_len  = '0;
    tx_data = '0;
    dev_low = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_rx_data", rx_data, 64'd0);
    check("rst_rx_count", 64'(rx_count), 64'd0);
    check("rst_line", 64'(dq), 64'd1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // TX bit timing: 0x01 -> seven '0' bits, one '1' bit, then stop
    do_start(4'd1, 4'd0, 64'h0100_0000_0000_0000);
    check("start_busy_n1", 64'(busy), 64'd1);
    check("no_drive_n1", 64'(dq), 64'd1);
    @(negedge clk);
    check("first_low_n2", 64'(dq), 64'd0);
    for (int i = 0; i < 8; i++) begin
      wait_level(1'b1, 1000, lo);
      wait_level(1'b0, 1000, hi);
      check($sformatf("tx_low_bit%0d", i), 64'(lo), (i == 7) ? 64'd100 : 64'd300);
      check($sformatf("tx_period_bit%0d", i), 64'(lo + hi), 64'd400);
    end
    wait_level(1'b1, 1000, lo);
    check("tx_stop_low", 64'(lo), 64'd100);
    check("tx_done_at_release", 64'(done), 64'd1);
    check("tx_busy_low_at_done", 64'(busy), 64'd0);
    check("tx_error", 64'(error), 64'd0);

    // Bad lengths, back-to-back with the previous done
    do_start(4'd0, 4'd1, 64'hFF00_0000_0000_0000);
    wait_done(4, n);
    check("txlen0_done_latency", 64'(n), 64'd1);
    check("txlen0_error", 64'(error), 64'd1);
    do_start(4'd9, 4'd1, 64'hFF00_0000_0000_0000);
    wait_done(4, n);
    check("txlen9_done", 64'(done), 64'd1);
    check("txlen9_error", 64'(error), 64'd1);
    do_start(4'd1, 4'd9, 64'hFF00_0000_0000_0000);
    wait_done(4, n);
    check("rxlen9_done", 64'(done), 64'd1);
    check("rxlen9_error", 64'(error), 64'd1);

    // Stuck bus: device releases just after the start is accepted; host must not drive
    repeat (5) @(negedge clk);
    dev_low = 1'b1;
    repeat (5) @(negedge clk);
    do_start(4'd1, 4'd0, 64'h0);
    dev_low = 1'b0;
    wait_done(4, n);
    check("stuck_done", 64'(done), 64'd1);
    check("stuck_error", 64'(error), 64'd1);
    drove = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dq !== 1'b1) drove = 1'b1;
    end
    check("stuck_never_driven", 64'(drove), 64'd0);

    // Start while busy is ignored: the transfer keeps its exact length and no error
    do_start(4'd1, 4'd0, 64'hFF00_0000_0000_0000);
    repeat (500) @(negedge clk);
    tx_len = 4'd0;
    rx_len = 4'd9;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, n);
    check("busy_start_total_cycles", 64'(501 + n), 64'd3301);
    check("busy_start_error", 64'(error), 64'd0);

    // Status command with a 3-byte reply
    do_start(4'd1, 4'd3, 64'h0);
    skip_host_tx(1);
    repeat (2 * Q) @(negedge clk);
    dev_send_byte(8'h05);
    dev_send_byte(8'h00);
    dev_send_byte(8'h02);
    dev_stop();
    wait_done(2000, n);
    check("status_done", 64'(done), 64'd1);
    check("status_error", 64'(error), 64'd0);
    check("status_rx_count", 64'(rx_count), 64'd3);
    check("status_rx_data", rx_data, 64'h0500_0200_0000_0000);

    // Silent device
    do_start(4'd1, 4'd4, 64'h0);
    skip_host_tx(1);
`ifdef JOYBUS_HOST_TIMEOUT_EN
    wait_done(8000, n);
    check("silent_done", 64'(done), 64'd1);
    check("silent_timeout_window", 64'(n >= 6397 && n <= 6403), 64'd1);
    check("silent_error", 64'(error), 64'd1);
    check("silent_rx_count", 64'(rx_count), 64'd0);
`else
    wait_done(7000, n);
    check("silent_no_done", 64'(n), 64'd7000);
    check("silent_still_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("silent_reset_recovers", 64'(busy), 64'd0);
`endif

    // Reset during a low pulse releases the line without a clock edge
    repeat (5) @(negedge clk);
    do_start(4'd1, 4'd0, 64'h0);
    wait_level(1'b0, 10, n);
    repeat (50) @(negedge clk);
    check("midtx_low", 64'(dq), 64'd0);
    reset_n = 1'b0;
    #1;
    check("midtx_rst_line", 64'(dq), 64'd1);
    check("midtx_rst_busy", 64'(busy), 64'd0);
    check("midtx_rst_done", 64'(done), 64'd0);
    check("midtx_rst_error", 64'(error), 64'd0);
    check("midtx_rst_rx_count", 64'(rx_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean run after reset with a 2-byte reply
    do_start(4'd1, 4'd2, 64'hFF00_0000_0000_0000);
    skip_host_tx(1);
    repeat (Q) @(negedge clk);
    dev_send_byte(8'hA5);
    dev_send_byte(8'h3C);
    dev_stop();
    wait_done(2000, n);
    check("rerun_done", 64'(done), 64'd1);
    check("rerun_error", 64'(error), 64'd0);
    check("rerun_rx_count", 64'(rx_count), 64'd2);
    check("rerun_rx_data", rx_data, 64'hA53C_0000_0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
